// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-ported data memory: CPU (A) has priority, B gets a forced grant after STARVE_LIMIT denials.
// Optional statistics counters are compiled in with `define DMEM_ARB_STATS_EN.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic [3:0]        a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_stall,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic [3:0]        b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       a_stall_cnt,
  output logic [15:0]       b_force_cnt,
  output logic [31:0]       conflict_cnt
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       force_b_q, force_b_d;
  logic       rd_pending_q, rd_pending_d;
  logic       rd_owner_q, rd_owner_d;

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    return (cnt >= LIMIT) ? LIMIT : cnt + 4'd1;
  endfunction

  // Grant: forced B beats A, A beats unforced B; never both.
  always_comb begin
    b_gnt = b_req & (force_b_q | ~a_req);
    a_gnt = a_req & ~b_gnt;
  end

  assign a_stall = a_req & ~a_gnt;

  always_comb begin
    mem_en   = a_gnt | b_gnt;
    mem_we   = 4'b0000;
    mem_addr = a_addr;
    mem_din  = a_wdata;
    if (b_gnt) begin
      mem_we   = b_we;
      mem_addr = b_addr;
      mem_din  = b_wdata;
    end else if (a_gnt) begin
      mem_we   = a_we;
    end
  end

  always_comb begin
    starve_cnt_d = 4'd0;
    if (b_req && !b_gnt)
      starve_cnt_d = sat_inc(starve_cnt_q);
    force_b_d    = (starve_cnt_d == LIMIT);
    // A zero write mask is a read; owner is whichever port held the grant.
    rd_pending_d = (a_gnt && (a_we == 4'b0000)) || (b_gnt && (b_we == 4'b0000));
    rd_owner_d   = b_gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= 4'd0;
      force_b_q    <= 1'b0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      force_b_q    <= force_b_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign a_rvalid = rd_pending_q & ~rd_owner_q;
  assign b_rvalid = rd_pending_q &  rd_owner_q;
  assign a_rdata  = mem_dout;
  assign b_rdata  = mem_dout;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] a_stall_cnt_q;
  logic [15:0] b_force_cnt_q;
  logic [31:0] conflict_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_stall_cnt_q  <= 32'd0;
      b_force_cnt_q  <= 16'd0;
      conflict_cnt_q <= 32'd0;
    end else begin
      if (a_stall)              a_stall_cnt_q  <= a_stall_cnt_q + 32'd1;
      if (force_b_q && b_req)   b_force_cnt_q  <= b_force_cnt_q + 16'd1;
      if (a_req && b_req)       conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  assign a_stall_cnt  = a_stall_cnt_q;
  assign b_force_cnt  = b_force_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural synchronous dmem.
module tb_dmem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, b_req;
  logic [3:0]  a_we, b_we;
  logic [13:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_gnt, a_stall, a_rvalid, b_gnt, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_din, mem_dout;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] a_stall_cnt, conflict_cnt;
  logic [15:0] b_force_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(14), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_stall(a_stall), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
`ifdef DMEM_ARB_STATS_EN
    , .a_stall_cnt(a_stall_cnt), .b_force_cnt(b_force_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  // Behavioural dmem: byte-masked write, read-before-write registered output.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_dout <= mem[mem_addr[7:0]];
      for (int k = 0; k < 4; k++)
        if (mem_we[k]) mem[mem_addr[7:0]][k*8 +: 8] <= mem_din[k*8 +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ar, input logic [3:0] aw, input logic [13:0] aa, input logic [31:0] ad,
                       input logic br, input logic [3:0] bw, input logic [13:0] ba, input logic [31:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  typedef struct packed {
    logic        a_req;
    logic [3:0]  a_we;
    logic [13:0] a_addr;
    logic [31:0] a_wdata;
    logic        b_req;
    logic [3:0]  b_we;
    logic [13:0] b_addr;
    logic [31:0] b_wdata;
    logic        e_agnt;
    logic        e_bgnt;
    logic        e_stall;
    logic        e_en;
    logic [3:0]  e_we;
    logic [13:0] e_addr;
    logic [31:0] e_din;
    logic        e_arv;
    logic        e_brv;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [0:10];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
    mem[8'h10] = 32'hAABBCCDD;
    mem[8'h20] = 32'h11223344;

    //              aR aWE    aADDR   aWDATA        bR bWE    bADDR   bWDATA        aG bG St En WE     ADDR    DIN           aRV bRV RDATA
    vecs[0]  = '{1'b1,4'h0,14'h010,32'h0,        1'b0,4'h0,14'h000,32'h0,        1'b1,1'b0,1'b0,1'b1,4'h0,14'h010,32'h0,        1'b0,1'b0,32'h0};
    vecs[1]  = '{1'b0,4'h0,14'h000,32'h0,        1'b0,4'h0,14'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,4'h0,14'h000,32'h0,        1'b1,1'b0,32'hAABBCCDD};
    vecs[2]  = '{1'b1,4'h4,14'h020,32'h00AB0000, 1'b1,4'h0,14'h020,32'h0,        1'b1,1'b0,1'b0,1'b1,4'h4,14'h020,32'h00AB0000, 1'b0,1'b0,32'h0};
    vecs[3]  = '{1'b0,4'h0,14'h000,32'h0,        1'b1,4'h0,14'h020,32'h0,        1'b0,1'b1,1'b0,1'b1,4'h0,14'h020,32'h0,        1'b0,1'b0,32'h0};
    vecs[4]  = '{1'b0,4'h0,14'h000,32'h0,        1'b0,4'h0,14'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,4'h0,14'h000,32'h0,        1'b0,1'b1,32'h11AB3344};
    vecs[5]  = '{1'b1,4'h0,14'h001,32'h0,        1'b0,4'h0,14'h000,32'h0,        1'b1,1'b0,1'b0,1'b1,4'h0,14'h001,32'h0,        1'b0,1'b0,32'h0};
    vecs[6]  = '{1'b0,4'h0,14'h000,32'h0,        1'b1,4'h0,14'h002,32'h0,        1'b0,1'b1,1'b0,1'b1,4'h0,14'h002,32'h0,        1'b1,1'b0,32'h10000001};
    vecs[7]  = '{1'b0,4'h0,14'h000,32'h0,        1'b0,4'h0,14'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,4'h0,14'h000,32'h0,        1'b0,1'b1,32'h10000002};
    vecs[8]  = '{1'b1,4'h0,14'h030,32'h0,        1'b0,4'h0,14'h000,32'h0,        1'b1,1'b0,1'b0,1'b1,4'h0,14'h030,32'h0,        1'b0,1'b0,32'h0};
    vecs[9]  = '{1'b0,4'h0,14'h000,32'h0,        1'b1,4'hF,14'h030,32'hDEADBEEF, 1'b0,1'b1,1'b0,1'b1,4'hF,14'h030,32'hDEADBEEF, 1'b1,1'b0,32'h10000030};
    vecs[10] = '{1'b0,4'h0,14'h000,32'h0,        1'b0,4'h0,14'h000,32'h0,        1'b0,1'b0,1'b0,1'b0,4'h0,14'h000,32'h0,        1'b0,1'b0,32'h0};

    // Reset state, with both ports requesting.
    rst_n = 1'b0;
    drive(1'b1, 4'h0, 14'h0, 32'h0, 1'b1, 4'h0, 14'h0, 32'h0);
    #3;
    chk("reset_arv", 32'(a_rvalid), 32'd0);
    chk("reset_brv", 32'(b_rvalid), 32'd0);
    chk("reset_agnt", 32'(a_gnt), 32'd1);
    chk("reset_bgnt", 32'(b_gnt), 32'd0);
    drive(1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 4'h0, 14'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      drive(vecs[i].a_req, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_wdata,
            vecs[i].b_req, vecs[i].b_we, vecs[i].b_addr, vecs[i].b_wdata);
      #1;
      chk($sformatf("v%0d_agnt", i), 32'(a_gnt), 32'(vecs[i].e_agnt));
      chk($sformatf("v%0d_bgnt", i), 32'(b_gnt), 32'(vecs[i].e_bgnt));
      chk($sformatf("v%0d_stall", i), 32'(a_stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_en", i), 32'(mem_en), 32'(vecs[i].e_en));
      chk($sformatf("v%0d_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d_din", i), mem_din, vecs[i].e_din);
      chk($sformatf("v%0d_arv", i), 32'(a_rvalid), 32'(vecs[i].e_arv));
      chk($sformatf("v%0d_brv", i), 32'(b_rvalid), 32'(vecs[i].e_brv));
      if (vecs[i].e_arv) chk($sformatf("v%0d_ardata", i), a_rdata, vecs[i].e_rdata);
      if (vecs[i].e_brv) chk($sformatf("v%0d_brdata", i), b_rdata, vecs[i].e_rdata);
    end

    // Continuous contention: B forced every fifth cycle.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(1'b1, 4'h0, 14'h001, 32'h0, 1'b1, 4'h0, 14'h002, 32'h0);
      #1;
      chk($sformatf("starve%0d_bgnt", c), 32'(b_gnt), 32'((c % 5) == 4));
      chk($sformatf("starve%0d_agnt", c), 32'(a_gnt), 32'((c % 5) != 4));
      chk($sformatf("starve%0d_stall", c), 32'(a_stall), 32'((c % 5) == 4));
      chk($sformatf("starve%0d_rv_excl", c), 32'(a_rvalid & b_rvalid), 32'd0);
    end
    @(negedge clk);
    drive(1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 4'h0, 14'h0, 32'h0);

    // B denied 3 cycles, withdraws, then re-requests: full limit applies again.
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      drive(1'b1, 4'h0, 14'h001, 32'h0, (c != 3), 4'h0, 14'h002, 32'h0);
      #1;
      chk($sformatf("drop%0d_bgnt", c), 32'(b_gnt), 32'(c == 8));
    end
    @(negedge clk);
    drive(1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 4'h0, 14'h0, 32'h0);
    #1;
`ifdef DMEM_ARB_STATS_EN
    chk("stats_force_cnt", 32'(b_force_cnt), 32'd3);
`endif

    // Async reset with a read in flight.
    @(negedge clk);
    drive(1'b1, 4'h0, 14'h010, 32'h0, 1'b0, 4'h0, 14'h0, 32'h0);
    #1;
    chk("rst_rd_agnt", 32'(a_gnt), 32'd1);
    @(negedge clk);
    drive(1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 4'h0, 14'h0, 32'h0);
    #1;
    chk("rst_pre_arv", 32'(a_rvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_arv", 32'(a_rvalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_post_arv", 32'(a_rvalid), 32'd0);
    chk("rst_post_brv", 32'(b_rvalid), 32'd0);
    @(negedge clk);
    #1;
    chk("rst_post2_arv", 32'(a_rvalid), 32'd0);
`ifdef DMEM_ARB_STATS_EN
    chk("stats_force_cnt_rst", 32'(b_force_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
